// File: rtl/fetch_stage.sv
// Instruction fetch stage: keeps one instruction-memory request in flight, buffers a response that arrives while decode stalls, and handles redirects.
// Optional feature macro: FETCH_PERF_CNT_EN adds delivered-instruction and stall-cycle counters.

package params_pkg;
    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;
    typedef logic [DATA_WIDTH-1:0] instruction_t;
endpackage

module fetch_stage
    import params_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = params_pkg::ADDR_WIDTH,
    parameter int unsigned           DATA_WIDTH = params_pkg::DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] BOOT_PC    = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_ready_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  valid_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output instruction_t          instruction_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetched_o,
    output logic [31:0]           perf_stall_o
`endif
);

    localparam instruction_t NOP = instruction_t'(32'h0000_0013);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_squash;
    logic [ADDR_WIDTH-1:0] r_hold_pc;
    instruction_t          r_hold_instr;

    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_pc_nxt;
    logic                  w_squash_nxt;
    logic                  w_valid_nxt;
    logic [ADDR_WIDTH-1:0] w_out_pc_nxt;
    instruction_t          w_instr_nxt;
    logic [ADDR_WIDTH-1:0] w_hold_pc_nxt;
    instruction_t          w_hold_instr_nxt;

    // Next-state logic; an output that decode consumes drops valid unless replaced.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_squash_nxt     = r_squash;
        w_valid_nxt      = valid_o & stall_i;
        w_out_pc_nxt     = pc_o;
        w_instr_nxt      = instruction_o;
        w_hold_pc_nxt    = r_hold_pc;
        w_hold_instr_nxt = r_hold_instr;
        if (redirect_i) begin
            w_valid_nxt  = 1'b0;
            w_pc_nxt     = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
            w_state_nxt  = REQ;
            w_squash_nxt = 1'b0;
            // A request still in flight must have its response discarded.
            if ((r_state == WAIT && !imem_rvalid_i) || (r_state == REQ && imem_ready_i)) begin
                w_state_nxt  = WAIT;
                w_squash_nxt = 1'b1;
            end
        end else begin
            unique case (r_state)
                IDLE: w_state_nxt = REQ;
                REQ: begin
                    if (imem_ready_i) w_state_nxt = WAIT;
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        if (r_squash) begin
                            w_squash_nxt = 1'b0;
                            w_state_nxt  = REQ;
                        end else if (!stall_i || !valid_o) begin
                            w_valid_nxt  = 1'b1;
                            w_out_pc_nxt = r_pc;
                            w_instr_nxt  = instruction_t'(imem_rdata_i);
                            w_pc_nxt     = r_pc + ADDR_WIDTH'(4);
                            w_state_nxt  = REQ;
                        end else begin
                            w_hold_pc_nxt    = r_pc;
                            w_hold_instr_nxt = instruction_t'(imem_rdata_i);
                            w_pc_nxt         = r_pc + ADDR_WIDTH'(4);
                            w_state_nxt      = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        w_valid_nxt  = 1'b1;
                        w_out_pc_nxt = r_hold_pc;
                        w_instr_nxt  = r_hold_instr;
                        w_state_nxt  = REQ;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // State and registered outputs; the memory request mirrors the next state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state       <= IDLE;
            r_pc          <= BOOT_PC;
            r_squash      <= 1'b0;
            r_hold_pc     <= '0;
            r_hold_instr  <= NOP;
            valid_o       <= 1'b0;
            pc_o          <= '0;
            instruction_o <= NOP;
            imem_req_o    <= 1'b0;
            imem_addr_o   <= BOOT_PC;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_squash      <= w_squash_nxt;
            r_hold_pc     <= w_hold_pc_nxt;
            r_hold_instr  <= w_hold_instr_nxt;
            valid_o       <= w_valid_nxt;
            pc_o          <= w_out_pc_nxt;
            instruction_o <= w_instr_nxt;
            imem_req_o    <= (w_state_nxt == REQ);
            imem_addr_o   <= w_pc_nxt;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic w_consume;
    assign w_consume = valid_o & ~stall_i;

    // Free-running wrap-around counters of deliveries and stalled-output cycles.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            perf_fetched_o <= '0;
            perf_stall_o   <= '0;
        end else begin
            if (w_consume)          perf_fetched_o <= perf_fetched_o + 32'(1);
            if (valid_o && stall_i) perf_stall_o   <= perf_stall_o + 32'(1);
        end
    end
`endif

endmodule
